irq_trap_unit: RTL and testbench
================================

Name: irq_trap_unit

Overview:
- Core-side consumer of the CLINT interrupt request/acknowledge interface.
- Arbitrates pending interrupt lines and waits for the pipeline to reach an interruptible point.
- Flushes the pipeline, saves the resume PC and redirects fetch to the handler vector, then acknowledges the CLINT.
- Handles return from the handler on mret. Sits between the CLINT and the fetch/execute stages.

Parameters:
IRQ_W, 4, number of interrupt lines (bit0 tim, bit1 uart_tx, bit2 uart_rx, bit3 fft)
ID_W, 2, width of the encoded interrupt id; must hold IRQ_W-1
VEC_BASE, 32'h0000_0040, address of the vector for interrupt id 0
VEC_STRIDE, 4, byte distance between consecutive vectors

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  reset, synchronous, active-high
irq_i  in  IRQ_W  level pending-interrupt vector from the CLINT
irq_ack_o  out  1  one-cycle acknowledge pulse to the CLINT
irq_ack_id_o  out  ID_W  id being acknowledged; valid only while irq_ack_o=1
int_en_i  in  1  global interrupt enable, from CSR
stall_i  in  1  pipeline is not interruptible this cycle
pc_i  in  32  PC of the oldest unretired instruction (resume address)
mret_i  in  1  mret decoded in execute
flush_o  out  1  one-cycle pipeline flush pulse
jump_o  out  1  one-cycle fetch redirect pulse
jump_addr_o  out  32  redirect target; valid while jump_o=1
epc_o  out  32  saved resume PC
cause_o  out  ID_W  id of the interrupt currently being serviced
in_isr_o  out  1  handler active

Behaviour:
- Registered FSM with states IDLE, WAIT, TAKE, ISR, RET.
- Reset: state IDLE; irq_ack_o, flush_o, jump_o and in_isr_o = 0; jump_addr_o, epc_o, cause_o and the latched id = 0.
- Reset applied in any state, including mid-ISR, aborts with no ack and no jump.
- All outputs are Moore outputs, decoded from registered state and registers.
- IDLE:
  - If int_en_i=1 and irq_i is non-zero, latch id = index of the lowest set bit (bit0 has highest priority) and go to WAIT.
  - stall_i is not checked in IDLE.
  - mret_i is ignored in IDLE.
- WAIT:
  - The latched id is frozen. Later or higher-priority lines are not re-arbitrated.
  - If int_en_i=0, return to IDLE with no ack.
  - Else if stall_i=0, capture epc_o <= pc_i and go to TAKE.
  - Else stay in WAIT.
  - mret_i is ignored in WAIT.
- TAKE (exactly 1 cycle):
  - Outputs: flush_o=1, jump_o=1, jump_addr_o = VEC_BASE + id*VEC_STRIDE (mod 2^32), irq_ack_o=1, irq_ack_id_o=id.
  - cause_o <= id.
  - Always goes to ISR. stall_i is ignored.
- ISR:
  - in_isr_o=1. No nesting: irq_i and int_en_i are ignored.
  - On mret_i=1, go to RET.
- RET (exactly 1 cycle):
  - Outputs: flush_o=1, jump_o=1, jump_addr_o = epc_o, in_isr_o=0.
  - Always goes to IDLE.
- A line still pending after RET is taken again from IDLE. At least one IDLE cycle separates RET and the next WAIT.
- Latency: irq sampled in IDLE at cycle n; with stall_i=0, the TAKE pulses appear in cycle n+2.
- epc_o and cause_o hold their values until the next TAKE or reset.
- pc_i is trusted as word-aligned. No alignment check is made.

Test Plan:
1. irq_i=4'b0100, int_en_i=1, stall_i=0, pc_i=0x100 at cycle 0 -> cycle 2: irq_ack_o=1, irq_ack_id_o=2, flush_o=jump_o=1, jump_addr_o=0x48, epc_o=0x100; cycle 3 onward: in_isr_o=1, cause_o=2.
2. irq_i=4'b1010 -> ack id 1, jump_addr_o=0x44. If bit0 rises during WAIT, the ack id is still 1.
3. stall_i=1 for 5 cycles after WAIT entry, with pc_i changing each cycle -> TAKE occurs the cycle after stall_i falls; epc_o equals pc_i on the last WAIT cycle.
4. In ISR, assert irq_i=4'b0001 -> no ack and no jump. Then pulse mret_i -> next cycle jump_o=1, jump_addr_o=epc_o, flush_o=1. Then one IDLE cycle, and id 0 is taken with ack two cycles later.
5. int_en_i dropped during WAIT -> returns to IDLE, irq_ack_o never asserted. Separately, rst=1 during ISR -> in_isr_o=0, epc_o=0 on the next cycle.
6. mret_i pulsed in IDLE and in WAIT -> no jump_o and no state change attributable to it.

Source files
------------

// File: rtl/irq_trap_unit.sv
// Interrupt trap sequencer: arbitrates CLINT lines, waits for an interruptible
// point, flushes/redirects fetch to the handler vector and returns on mret.
module irq_trap_unit #(
  parameter int          IRQ_W      = 4,
  parameter int          ID_W       = 2,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0040,
  parameter int          VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_W-1:0] irq_i,
  output logic             irq_ack_o,
  output logic [ID_W-1:0]  irq_ack_id_o,
  input  logic             int_en_i,
  input  logic             stall_i,
  input  logic [31:0]      pc_i,
  input  logic             mret_i,
  output logic             flush_o,
  output logic             jump_o,
  output logic [31:0]      jump_addr_o,
  output logic [31:0]      epc_o,
  output logic [ID_W-1:0]  cause_o,
  output logic             in_isr_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_TAKE = 3'd2;
  localparam logic [2:0] S_ISR  = 3'd3;
  localparam logic [2:0] S_RET  = 3'd4;

  logic [2:0]      state;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] pick_id;
  logic [31:0]     epc_q;
  logic [ID_W-1:0] cause_q;
  logic [31:0]     vec_addr;

  // Scan from the top down so the lowest set bit wins (bit0 = highest priority).
  always_comb begin
    pick_id = '0;
    for (int i = IRQ_W - 1; i >= 0; i--)
      if (irq_i[i]) pick_id = ID_W'(i);
  end

  assign vec_addr = VEC_BASE + 32'(id_q) * 32'(VEC_STRIDE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      id_q    <= '0;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (int_en_i && (|irq_i)) begin
            id_q  <= pick_id;
            state <= S_WAIT;
          end
        end
        // id_q stays frozen here; no re-arbitration against newer lines.
        S_WAIT: begin
          if (!int_en_i) begin
            state <= S_IDLE;
          end else if (!stall_i) begin
            epc_q <= pc_i;
            state <= S_TAKE;
          end
        end
        S_TAKE: begin
          cause_q <= id_q;
          state   <= S_ISR;
        end
        S_ISR: begin
          if (mret_i) state <= S_RET;
        end
        S_RET:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode: pulses are one cycle wide because TAKE/RET last one cycle.
  assign irq_ack_o    = (state == S_TAKE);
  assign irq_ack_id_o = (state == S_TAKE) ? id_q : '0;
  assign flush_o      = (state == S_TAKE) || (state == S_RET);
  assign jump_o       = (state == S_TAKE) || (state == S_RET);
  assign jump_addr_o  = (state == S_TAKE) ? vec_addr :
                        (state == S_RET)  ? epc_q    : 32'h0;
  assign epc_o        = epc_q;
  assign cause_o      = cause_q;
  assign in_isr_o     = (state == S_ISR);

endmodule

// File: tb/tb_irq_trap_unit.sv
// Bench for irq_trap_unit: vector table plus hand sequences, acks scored
// against a queue of expected {id, vector, epc}.
module tb_irq_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_i;
  logic        irq_ack_o;
  logic [1:0]  irq_ack_id_o;
  logic        int_en_i;
  logic        stall_i;
  logic [31:0] pc_i;
  logic        mret_i;
  logic        flush_o;
  logic        jump_o;
  logic [31:0] jump_addr_o;
  logic [31:0] epc_o;
  logic [1:0]  cause_o;
  logic        in_isr_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] addr;
    logic [31:0] epc;
  } exp_t;

  typedef struct {
    logic [3:0]  irq;
    logic        en;
    logic [31:0] pc;
    logic        take;
    logic [1:0]  id;
    logic [31:0] addr;
  } vec_t;

  exp_t sb[$];

  irq_trap_unit dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .irq_ack_o(irq_ack_o),
    .irq_ack_id_o(irq_ack_id_o), .int_en_i(int_en_i), .stall_i(stall_i),
    .pc_i(pc_i), .mret_i(mret_i), .flush_o(flush_o), .jump_o(jump_o),
    .jump_addr_o(jump_addr_o), .epc_o(epc_o), .cause_o(cause_o),
    .in_isr_o(in_isr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && irq_ack_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got id %0d want none @%0t", irq_ack_id_o, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_id", 32'(irq_ack_id_o), 32'(e.id));
        chk("ack_addr", jump_addr_o, e.addr);
        chk("ack_epc", epc_o, e.epc);
        chk("ack_flush", 32'({flush_o, jump_o}), 32'h3);
      end
    end
  end

  // Called in the TAKE cycle: walk through ISR, mret, RET and back to IDLE.
  task automatic finish_isr(input logic [31:0] epc, input logic [1:0] cause);
    step();
    chk("isr_in", 32'(in_isr_o), 32'h1);
    chk("isr_cause", 32'(cause_o), 32'(cause));
    chk("isr_epc", epc_o, epc);
    mret_i = 1'b1;
    step();
    chk("ret_jump", 32'({jump_o, flush_o, in_isr_o}), 32'h6);
    chk("ret_addr", jump_addr_o, epc);
    mret_i = 1'b0;
    step();
    chk("ret_idle", 32'({jump_o, in_isr_o}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    tbl[0] = '{4'b0100, 1'b1, 32'h100, 1'b1, 2'd2, 32'h48};
    tbl[1] = '{4'b1010, 1'b1, 32'h104, 1'b1, 2'd1, 32'h44};
    tbl[2] = '{4'b1000, 1'b1, 32'h108, 1'b1, 2'd3, 32'h4C};
    tbl[3] = '{4'b0001, 1'b1, 32'h10C, 1'b1, 2'd0, 32'h40};
    tbl[4] = '{4'b1111, 1'b1, 32'h110, 1'b1, 2'd0, 32'h40};
    tbl[5] = '{4'b1100, 1'b1, 32'h114, 1'b1, 2'd2, 32'h48};
    tbl[6] = '{4'b0110, 1'b0, 32'h118, 1'b0, 2'd0, 32'h0};

    rst = 1'b1; irq_i = '0; int_en_i = 1'b0; stall_i = 1'b0;
    pc_i = '0; mret_i = 1'b0;
    step(); step();
    chk("rst_ctl", 32'({irq_ack_o, flush_o, jump_o, in_isr_o}), 32'h0);
    chk("rst_addr", jump_addr_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_cause", 32'(cause_o), 32'h0);
    rst = 1'b0;
    step();

    // Vector table: cycle-0 irq gives TAKE in cycle 2.
    for (int v = 0; v < 7; v++) begin
      irq_i = tbl[v].irq; int_en_i = tbl[v].en; pc_i = tbl[v].pc;
      if (tbl[v].take) sb.push_back('{tbl[v].id, tbl[v].addr, tbl[v].pc});
      step();
      step();
      chk("tbl_take", 32'(irq_ack_o), 32'(tbl[v].take));
      irq_i = '0;
      if (tbl[v].take) finish_isr(tbl[v].pc, tbl[v].id);
      else begin
        step(); step();
        chk("tbl_noisr", 32'({in_isr_o, jump_o}), 32'h0);
      end
      int_en_i = 1'b1;
    end

    // Higher-priority line rising during WAIT does not change the id.
    irq_i = 4'b1010; pc_i = 32'h200;
    sb.push_back('{2'd1, 32'h44, 32'h200});
    step();
    irq_i = 4'b1011;
    step();
    chk("frz_ack", 32'(irq_ack_o), 32'h1);
    irq_i = '0;
    finish_isr(32'h200, 2'd1);

    // Stall holds WAIT; epc is pc on the last WAIT cycle.
    irq_i = 4'b0010; pc_i = 32'h300; stall_i = 1'b1;
    sb.push_back('{2'd1, 32'h44, 32'h500});
    step();
    for (int k = 0; k < 5; k++) begin
      pc_i = 32'h400 + 32'(4 * k);
      chk("stall_noack", 32'(irq_ack_o), 32'h0);
      step();
    end
    pc_i = 32'h500; stall_i = 1'b0;
    chk("stall_wait", 32'(irq_ack_o), 32'h0);
    step();
    chk("stall_take", 32'(irq_ack_o), 32'h1);
    irq_i = '0; pc_i = 32'h504;
    finish_isr(32'h500, 2'd1);

    // No nesting in ISR; pending line retaken after RET.
    irq_i = 4'b0100; pc_i = 32'h600;
    sb.push_back('{2'd2, 32'h48, 32'h600});
    step(); step();
    chk("nest_take", 32'(irq_ack_o), 32'h1);
    irq_i = '0;
    step();
    irq_i = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("nest_hold", 32'({in_isr_o, irq_ack_o, jump_o}), 32'h4);
    end
    mret_i = 1'b1;
    step();
    chk("nest_ret", 32'({jump_o, flush_o}), 32'h3);
    chk("nest_retaddr", jump_addr_o, 32'h600);
    mret_i = 1'b0; pc_i = 32'h700;
    sb.push_back('{2'd0, 32'h40, 32'h700});
    step();
    chk("nest_idle", 32'({in_isr_o, irq_ack_o, jump_o}), 32'h0);
    step();
    chk("nest_wait", 32'(irq_ack_o), 32'h0);
    step();
    chk("nest_retake", 32'(irq_ack_o), 32'h1);
    irq_i = '0;
    finish_isr(32'h700, 2'd0);

    // int_en dropped during WAIT abandons the request.
    irq_i = 4'b1000; stall_i = 1'b1;
    step();
    int_en_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("dis_noack", 32'({irq_ack_o, jump_o, in_isr_o}), 32'h0);
    end
    irq_i = '0; int_en_i = 1'b1; stall_i = 1'b0;
    step();

    // Reset mid-ISR clears everything.
    irq_i = 4'b1000; pc_i = 32'h800;
    sb.push_back('{2'd3, 32'h4C, 32'h800});
    step(); step();
    chk("rsti_take", 32'(irq_ack_o), 32'h1);
    irq_i = '0;
    step();
    chk("rsti_isr", 32'(in_isr_o), 32'h1);
    rst = 1'b1;
    step();
    chk("rsti_ctl", 32'({in_isr_o, jump_o, irq_ack_o}), 32'h0);
    chk("rsti_epc", epc_o, 32'h0);
    chk("rsti_cause", 32'(cause_o), 32'h0);
    rst = 1'b0;
    step();

    // mret in IDLE and WAIT has no effect.
    mret_i = 1'b1;
    step();
    chk("mret_idle", 32'({jump_o, flush_o, in_isr_o}), 32'h0);
    irq_i = 4'b0001; pc_i = 32'h900; stall_i = 1'b1;
    sb.push_back('{2'd0, 32'h40, 32'h900});
    step();
    chk("mret_wait1", 32'({jump_o, irq_ack_o}), 32'h0);
    step();
    chk("mret_wait2", 32'({jump_o, irq_ack_o}), 32'h0);
    stall_i = 1'b0;
    step();
    chk("mret_take", 32'(irq_ack_o), 32'h1);
    mret_i = 1'b0; irq_i = '0;
    finish_isr(32'h900, 2'd0);

    step();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
